// File: rtl/dcm_supervisor_pkg.sv
// Shared types and constants for the DCM supervisor.
package dcm_sup_pkg;

  // Supervisor states; encodings are visible on the STATE debug output.
  typedef enum logic [2:0] {
    RST_DCM   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } dcm_state_e;

  // Bit positions inside the DCM STATUS bus.
  localparam int ST_CLKIN_STOP = 1;
  localparam int ST_CLKFX_STOP = 2;

  // Saturating increment for the 8-bit attempt counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dcm_supervisor_if.sv
// Signals between the DCM supervisor and its surroundings (DCM, reset tree, debug).
interface dcm_supervisor_if;
  logic       force_relock;
  logic       dcm_locked;
  logic [7:0] dcm_status;
  logic       dcm_rst;
  logic       sys_rst;
  logic       clk_ok;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [2:0] state;

  // Environment side: drives requests and DCM status, observes control outputs.
  modport master (
    output force_relock, dcm_locked, dcm_status,
    input  dcm_rst, sys_rst, clk_ok, fail, retry_cnt, state
  );

  // Supervisor side.
  modport slave (
    input  force_relock, dcm_locked, dcm_status,
    output dcm_rst, sys_rst, clk_ok, fail, retry_cnt, state
  );
endinterface

// File: rtl/dcm_supervisor_sync2.sv
// Two-flop synchronizer for signals arriving asynchronously to clk_i.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so sync_q takes the previous meta_q, forming a real two-stage chain.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dcm_supervisor.sv
// DCM bring-up sequencer and lock supervisor; runs only on CLKIN so it survives a dead CLKFX.
module dcm_supervisor
  import dcm_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int SETTLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7,
  parameter int CNT_W         = 16
) (
  input logic             clkin_i,
  input logic             rst_i,
  dcm_supervisor_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       FAIL_LAST   = 8'(MAX_RETRIES - 1);

  logic [2:0] sync_in;
  logic [2:0] sync_out;
  logic       lk;
  logic       fxs;
  logic       unused_bits;

  dcm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       fail_cnt_q, fail_cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             attempt_failed;
  logic             dcm_rst_q, sys_rst_q, clk_ok_q, fail_q;

  assign sync_in = {bus.dcm_status[ST_CLKFX_STOP], bus.dcm_status[ST_CLKIN_STOP], bus.dcm_locked};

  sync2 #(.WIDTH(3)) u_sync (
    .clk_i (clkin_i),
    .rst_i (rst_i),
    .d_i   (sync_in),
    .q_o   (sync_out)
  );

  assign lk  = sync_out[0];
  assign fxs = sync_out[2];
  // CLKIN-stopped is synchronized for debug only; nothing here can react to a stopped CLKIN.
  assign unused_bits = ^{bus.dcm_status[7:3], bus.dcm_status[0], sync_out[1]};

  // Next-state, counter and attempt bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the branches so no path leaves it unassigned (no latch).
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    fail_cnt_d     = fail_cnt_q;
    retry_d        = retry_q;
    attempt_failed = 1'b0;

    if (bus.force_relock) begin
      // A forced re-lock wins over everything and starts a fresh sequence.
      state_d    = RST_DCM;
      fail_cnt_d = '0;
      if (state_q != RST_DCM) retry_d = sat_inc8(retry_q);
    end else begin
      case (state_q)
        RST_DCM:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lk)                      state_d = SETTLE;
          else if (cnt_q == LOCK_LAST) attempt_failed = 1'b1;
        end
        SETTLE: begin
          if (!lk || fxs)                attempt_failed = 1'b1;
          else if (cnt_q == SETTLE_LAST) state_d = RUN;
        end
        RUN: begin
          // Loss after a good lock restarts without counting against the retry budget.
          if (!lk || fxs) begin
            state_d = RST_DCM;
            retry_d = sat_inc8(retry_q);
          end
        end
        FAIL:    state_d = FAIL;
        default: state_d = RST_DCM;
      endcase

      if (attempt_failed) begin
        fail_cnt_d = fail_cnt_q + 8'd1;
        retry_d    = sat_inc8(retry_q);
        state_d    = (fail_cnt_q == FAIL_LAST) ? FAIL : RST_DCM;
      end

      if (state_d == RUN && state_q != RUN) fail_cnt_d = '0;
    end

    // Counter restarts on every entry (including a forced re-entry) and idles in untimed states.
    if (state_d != state_q || bus.force_relock || state_d inside {RUN, FAIL}) cnt_d = '0;
  end

  // State, bookkeeping and registered outputs derived from the state being entered.
  always_ff @(posedge clkin_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RST_DCM;
      cnt_q      <= '0;
      fail_cnt_q <= '0;
      retry_q    <= '0;
      dcm_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      clk_ok_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fail_cnt_q <= fail_cnt_d;
      retry_q    <= retry_d;
      dcm_rst_q  <= (state_d == RST_DCM) || (state_d == FAIL);
      sys_rst_q  <= (state_d != RUN);
      clk_ok_q   <= (state_d == RUN);
      fail_q     <= (state_d == FAIL);
    end
  end

  assign bus.dcm_rst   = dcm_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.clk_ok    = clk_ok_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state     = state_q;

endmodule

// File: doc/dcm_supervisor.md
Name: dcm_supervisor

Overview:
- Sequences and supervises the DCM clock synthesizer (24 MHz CLKIN to about 21.43 MHz CLKFX).
- Pulses DCM reset, waits for LOCKED, and requires lock to hold for a settle period before releasing the downstream reset.
- Watches for loss of lock or a stopped CLKFX, and retries with bounded attempts.
- Runs entirely on CLKIN so that it keeps operating when CLKFX is dead. Sits between the top-level reset input and the my_dcm instance.

Parameters:
- RST_CYCLES, 4, number of CLKIN cycles DCM_RST is held high per attempt (minimum 3).
- LOCK_TIMEOUT, 24000, CLKIN cycles allowed from DCM_RST release to LOCKED (1 ms).
- SETTLE_CYCLES, 256, consecutive CLKIN cycles LOCKED must stay high before SYS_RST is released.
- MAX_RETRIES, 7, consecutive failed attempts before entering FAIL.
- CNT_W, 16, width of the shared cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES).

Ports:
- CLKIN  in  1  24 MHz input clock; the only clock in the block.
- RST  in  1  asynchronous, active-high reset.
- FORCE_RELOCK  in  1  single-cycle pulse that requests a full DCM re-lock.
- DCM_LOCKED  in  1  DCM LOCKED output; asynchronous to this block.
- DCM_STATUS  in  8  DCM STATUS bus; asynchronous. Bit 1 = CLKIN stopped, bit 2 = CLKFX stopped.
- DCM_RST  out  1  drives the DCM RST input.
- SYS_RST  out  1  active-high reset for logic in the CLKFX domain.
- CLK_OK  out  1  high only in state RUN.
- FAIL  out  1  high in state FAIL.
- RETRY_CNT  out  8  total re-lock attempts since RST; saturates at 255.
- STATE  out  3  current state encoding, for debug.

Behaviour:
- Reset values while RST is high: state RST_DCM, DCM_RST=1, SYS_RST=1, CLK_OK=0, FAIL=0, RETRY_CNT=0, cycle counter=0, fail_cnt=0, synchronizers=0.
- Synchronizers: DCM_LOCKED, DCM_STATUS[1] and DCM_STATUS[2] each pass through a 2-flop synchronizer. All decisions below use the synchronized values (lk, fxs). Minimum detection latency is 2 cycles.
- Shared counter: one CNT_W-bit counter. It is cleared on every state entry and increments each cycle while in the state. It never wraps, because every state exits before its limit is exceeded.
- State RST_DCM (0):
  - DCM_RST=1.
  - After RST_CYCLES cycles, go to WAIT_LOCK.
- State WAIT_LOCK (1):
  - DCM_RST=0.
  - If lk=1, go to SETTLE.
  - Else, when counter reaches LOCK_TIMEOUT-1, the attempt has failed.
- State SETTLE (2):
  - If lk=0 or fxs=1, the attempt has failed.
  - Else, when counter reaches SETTLE_CYCLES-1, go to RUN.
- Failed attempt:
  - fail_cnt is incremented and RETRY_CNT is incremented (saturating).
  - If the new fail_cnt equals MAX_RETRIES, go to FAIL; otherwise go to RST_DCM.
- State RUN (3):
  - SYS_RST=0 and CLK_OK=1, both registered, taking effect on the first cycle in RUN. fail_cnt is cleared on entry.
  - If lk=0 or fxs=1, go to RST_DCM and increment RETRY_CNT. fail_cnt is not incremented; the loss counts as a fresh sequence.
  - SYS_RST reasserts (1) on the same edge that leaves RUN.
- State FAIL (4):
  - DCM_RST=1, SYS_RST=1, FAIL=1.
  - The block stays in FAIL until FORCE_RELOCK or RST.
- FORCE_RELOCK, in any state:
  - Go to RST_DCM next cycle and clear fail_cnt.
  - From FAIL, it also clears FAIL. RETRY_CNT increments except when the block is already in RST_DCM.
  - FORCE_RELOCK has priority over every other transition in the same cycle.
- SYS_RST is high in every state except RUN. It is asynchronously asserted by RST. Downstream logic synchronizes its release into the CLKFX domain.
- STATUS[1] (CLKIN stopped) is synchronized and exposed only in STATE debug logic. No transition depends on it, because this block runs on CLKIN.
- Unused STATE encodings 5-7 go to RST_DCM.

Decomposition:
- Package dcm_sup_pkg:
  - State enum: RST_DCM=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAIL=4.
  - STATUS bit index constants: ST_CLKIN_STOP=1, ST_CLKFX_STOP=2.
- Sub-module sync2: a 2-flop synchronizer with async active-high reset, parameterized width. It is instantiated once, with width 3, for LOCKED, STATUS[1] and STATUS[2].

Test Plan:
(Sim parameters: RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, MAX_RETRIES=3.)
- Nominal lock:
  - Stimulus: release RST; raise DCM_LOCKED 10 cycles after DCM_RST falls.
  - Required: DCM_RST high for exactly 4 cycles; SYS_RST falls and CLK_OK rises 2+8 cycles after DCM_LOCKED rises; RETRY_CNT=0.
- Timeout to FAIL:
  - Stimulus: hold DCM_LOCKED=0.
  - Required: 3 DCM_RST pulses, each followed by a 50-cycle wait; then FAIL=1, STATE=4, RETRY_CNT=3, DCM_RST stays high.
- Glitch during SETTLE:
  - Stimulus: DCM_LOCKED drops for 3 cycles, 4 cycles into SETTLE.
  - Required: return to RST_DCM, RETRY_CNT=1, SYS_RST never deasserted; the next clean lock reaches RUN.
- Loss in RUN:
  - Stimulus: in RUN, set DCM_STATUS[2]=1.
  - Required: 2 cycles later CLK_OK=0, SYS_RST=1, DCM_RST=1, RETRY_CNT increments by 1.
- Recovery from FAIL:
  - Stimulus: in FAIL, pulse FORCE_RELOCK with DCM_LOCKED=1.
  - Required: FAIL clears next cycle, the sequence reaches RUN after 4+1+8 cycles (plus sync latency), fail_cnt=0.
- Async reset mid-SETTLE:
  - Stimulus: pulse RST asynchronously.
  - Required: all outputs take their reset values immediately, with no clock edge needed.
